uart_tx: RTL

Serial transmitter peripheral sitting directly downstream of the CORE-side read/write register block. It consumes the held register outputs (transmit byte, baud divisor) plus the write-enable strobe of the data register as a start pulse, and produces an asynchronous serial frame on `txd`. Its `busy` and `done` outputs feed a read-only status register back toward the bus.

---
 rtl/uart_tx_if.sv | 23 ++
 rtl/uart_tx.sv | 111 +++++++++++
 2 files changed

// File: rtl/uart_tx_if.sv
// Handshake bundle between the register block and the UART transmitter.
// The register side (master) drives the held data/divisor and the start strobe.
// The transmitter (slave) returns the serial line and its status bits.
interface uart_tx_if #(
    parameter int DIV_BW = 16
);
    logic [7:0]        txdata;
    logic              txstart;
    logic [DIV_BW-1:0] baud_div;
    logic              txd;
    logic              busy;
    logic              done;

    modport master (
        output txdata, txstart, baud_div,
        input  txd, busy, done
    );

    modport slave (
        input  txdata, txstart, baud_div,
        output txd, busy, done
    );
endinterface

// File: rtl/uart_tx.sv
// Asynchronous serial transmitter: start bit, 8 data bits LSB first,
// optional parity bit, one stop bit. Every bit lasts baud_div+1 clocks.
// Data, divisor and parity are latched at accept time.
module uart_tx #(
    parameter int DIV_BW = 16,
    parameter int PARITY = 0
) (
    input logic   clk,
    input logic   rst_n,
    uart_tx_if.slave bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    localparam bit PAR_EN  = (PARITY == 1) || (PARITY == 2);
    localparam bit PAR_ODD = (PARITY == 2);

    logic [2:0]        state;
    logic [7:0]        shreg;
    logic [DIV_BW-1:0] div_q;
    logic [DIV_BW-1:0] cnt;
    logic [2:0]        bit_idx;
    logic              par_q;
    logic              txd_q;
    logic              busy_q;
    logic              done_q;

    assign bus.txd  = txd_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

    // Frame sequencer: accepts a request in IDLE, then steps one bit per divisor period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            shreg   <= '0;
            div_q   <= '0;
            cnt     <= '0;
            bit_idx <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == S_IDLE) begin
                txd_q  <= 1'b1;
                busy_q <= 1'b0;
                if (bus.txstart) begin
                    shreg   <= bus.txdata;
                    div_q   <= bus.baud_div;
                    par_q   <= PAR_ODD ? ~^bus.txdata : ^bus.txdata;
                    cnt     <= '0;
                    bit_idx <= '0;
                    state   <= S_START;
                    txd_q   <= 1'b0;
                    busy_q  <= 1'b1;
                end
            end else if (cnt == div_q) begin
                // Bit boundary: reload the divisor counter and present the next bit.
                cnt <= '0;
                case (state)
                    S_START: begin
                        txd_q   <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= '0;
                        state   <= S_DATA;
                    end
                    S_DATA: begin
                        if (bit_idx == 3'd7) begin
                            if (PAR_EN) begin
                                txd_q <= par_q;
                                state <= S_PAR;
                            end else begin
                                txd_q <= 1'b1;
                                state <= S_STOP;
                            end
                        end else begin
                            txd_q   <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                    S_PAR: begin
                        txd_q <= 1'b1;
                        state <= S_STOP;
                    end
                    S_STOP: begin
                        txd_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        bit_idx <= '0;
                        state   <= S_IDLE;
                    end
                    default: begin
                        txd_q  <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end
                endcase
            end else begin
                cnt <= cnt + DIV_BW'(1);
            end
        end
    end

endmodule
